// File: rtl/mem_bus_decoder.sv
// mem_bus_decoder
//   Bridges a core load/store port to NUM_SLV memory-mapped slaves.
//   The address is decoded against a base/mask table, and store data is steered
//   onto byte lanes. Load data is shifted down and sign- or zero-extended. Each
//   access is held on the slave side until that slave signals s_ready, or until
//   TIMEOUT wait cycles have passed, whichever comes first.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   m_req            request valid; the master holds it until m_ready
//   m_we             1 = store, 0 = load
//   m_addr           byte address
//   m_wdata          right-aligned store data
//   m_size           0 = byte, 1 = half, 2 = word, 3 = illegal
//   m_unsigned       zero-extend loads
//   m_rdata          load result, valid with m_ready (0 on stores and errors)
//   m_ready          one-cycle response strobe
//   m_err            error qualifier, valid with m_ready
//   s_sel            one-hot slave select (ACCESS state only)
//   s_we             write enable, qualified by s_sel
//   s_addr           word offset inside the selected window
//   s_wdata          lane-replicated store data
//   s_be             byte enables
//   s_rdata          packed slave read data, slot 0 in the LSBs
//   s_ready          slave completion; only the selected slot is looked at
//   s_rd_pulse       one-cycle pulse in RESP after a successful load of a slot
//   dbg_state        current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//
// Handshake: the master raises m_req and keeps its request fields stable
// until it sees m_ready. m_ready is a single-cycle strobe. The earliest next
// request is accepted in the cycle after m_ready. On the slave side, s_sel stays
// high with stable s_we/s_addr/s_wdata/s_be until the cycle in which
// s_ready[slot] is 1. That cycle ends the access.
module mem_bus_decoder #(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE =
    {32'h1000_0010, 32'h1000_0000, 32'h1001_0000, 32'h0040_0000},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK =
    {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_0000, 32'hFFC0_0000}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_req,
  input  logic                  m_we,
  input  logic [ADDR_W-1:0]     m_addr,
  input  logic [31:0]           m_wdata,
  input  logic [1:0]            m_size,
  input  logic                  m_unsigned,
  output logic [31:0]           m_rdata,
  output logic                  m_ready,
  output logic                  m_err,
  output logic [NUM_SLV-1:0]    s_sel,
  output logic                  s_we,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_be,
  input  logic [NUM_SLV*32-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]    s_ready,
  output logic [NUM_SLV-1:0]    s_rd_pulse,
  output logic [1:0]            dbg_state
);

  localparam int SLOT_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] saddr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  // ---------------------------------------------------------------
  // Address decode. The loop runs from the highest slot down, so the
  // lowest matching slot overwrites the others and wins.
  // ---------------------------------------------------------------
  logic              hit;
  logic [SLOT_W-1:0] hit_idx;
  logic [ADDR_W-1:0] hit_base;
  logic [ADDR_W-1:0] hit_diff;

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_base = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit      = 1'b1;
        hit_idx  = SLOT_W'(i);
        hit_base = SLV_BASE[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign hit_diff = m_addr - hit_base;

  // Alignment check; size 3 is always rejected.
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    case (m_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = m_addr[0];
      2'd2:    misaligned = (m_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  logic req_legal;
  assign req_legal = hit && !misaligned;

  // Store lane steering, computed from the live request and captured at accept.
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  always_comb begin
    be_d    = 4'h0;
    wdata_d = 32'h0;
    case (m_size)
      2'd0: begin
        be_d    = 4'b0001 << m_addr[1:0];
        wdata_d = {4{m_wdata[7:0]}};
      end
      2'd1: begin
        be_d    = 4'b0011 << m_addr[1:0];
        wdata_d = {2{m_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'hF;
        wdata_d = m_wdata;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Load formatting for the selected slot.
  // ---------------------------------------------------------------
  logic [31:0] slot_rdata;
  logic [31:0] shifted;
  logic [31:0] fmt_rdata;
  logic        slot_ready;

  assign slot_rdata = s_rdata[slot_q*32 +: 32];
  assign slot_ready = s_ready[slot_q];
  assign shifted    = slot_rdata >> {lane_q, 3'b000};

  always_comb begin
    fmt_rdata = 32'h0;
    case (size_q)
      2'd0:    fmt_rdata = {{24{shifted[7]  & ~uns_q}}, shifted[7:0]};
      2'd1:    fmt_rdata = {{16{shifted[15] & ~uns_q}}, shifted[15:0]};
      default: fmt_rdata = shifted;
    endcase
  end

  // ---------------------------------------------------------------
  // FSM next state / control
  // ---------------------------------------------------------------
  logic capture;    // IDLE accepts a request
  logic set_err;    // going to RESP with an error
  logic set_ok;     // going to RESP after slave completion

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    set_err = 1'b0;
    set_ok  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m_req) begin
          capture = 1'b1;
          if (req_legal) begin
            state_d = ACCESS;
          end else begin
            state_d = RESP;
            set_err = 1'b1;
          end
        end
      end
      ACCESS: begin
        // Ready is checked first, so it still counts as success on the
        // last permitted wait cycle.
        if (slot_ready) begin
          state_d = RESP;
          set_ok  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          set_err = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      lane_q  <= 2'd0;
      saddr_q <= '0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        slot_q  <= hit_idx;
        we_q    <= m_we;
        size_q  <= m_size;
        uns_q   <= m_unsigned;
        lane_q  <= m_addr[1:0];
        saddr_q <= {2'b00, hit_diff[ADDR_W-1:2]};
        be_q    <= be_d;
        wdata_q <= wdata_d;
      end
      if (set_err) begin
        err_q   <= 1'b1;
        rdata_q <= 32'h0;
      end else if (set_ok) begin
        err_q   <= 1'b0;
        rdata_q <= we_q ? 32'h0 : fmt_rdata;
      end
    end
  end

  // ---------------------------------------------------------------
  // Outputs. They are all decoded from the state, so IDLE (and therefore
  // reset) drives every output to zero.
  // ---------------------------------------------------------------
  logic [NUM_SLV-1:0] slot_onehot;
  assign slot_onehot = NUM_SLV'(1) << slot_q;

  assign m_ready    = (state_q == RESP);
  assign m_err      = (state_q == RESP) && err_q;
  assign m_rdata    = (state_q == RESP) ? rdata_q : 32'h0;
  assign s_sel      = (state_q == ACCESS) ? slot_onehot : '0;
  assign s_we       = (state_q == ACCESS) && we_q;
  assign s_addr     = (state_q == ACCESS) ? saddr_q : '0;
  assign s_wdata    = (state_q == ACCESS) ? wdata_q : 32'h0;
  assign s_be       = (state_q == ACCESS) ? be_q : 4'h0;
  assign s_rd_pulse = ((state_q == RESP) && !err_q && !we_q) ? slot_onehot : '0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
module tb_mem_bus_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_req;
  logic         m_we;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [1:0]   m_size;
  logic         m_unsigned;
  logic [31:0]  m_rdata;
  logic         m_ready;
  logic         m_err;
  logic [3:0]   s_sel;
  logic         s_we;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_be;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;
  logic [3:0]   s_rd_pulse;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  mem_bus_decoder dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_size(m_size), .m_unsigned(m_unsigned),
    .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
    .s_rdata(s_rdata), .s_ready(s_ready), .s_rd_pulse(s_rd_pulse),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    int          waits;
    logic [31:0] srd;
    int          e_lat;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [3:0]  e_sel;
    logic [31:0] e_saddr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [3:0]  e_pulse;
  } vec_t;

  typedef struct {
    int          lat;
    int          sel_cyc;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] saddr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [3:0]  pulse;
    logic [4:0]  after;
  } obs_t;

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_m_rdata"},    m_rdata, 32'h0);
    chk({pfx, "_m_ready"},    {31'h0, m_ready}, 32'h0);
    chk({pfx, "_m_err"},      {31'h0, m_err}, 32'h0);
    chk({pfx, "_s_sel"},      {28'h0, s_sel}, 32'h0);
    chk({pfx, "_s_we"},       {31'h0, s_we}, 32'h0);
    chk({pfx, "_s_addr"},     s_addr, 32'h0);
    chk({pfx, "_s_wdata"},    s_wdata, 32'h0);
    chk({pfx, "_s_be"},       {28'h0, s_be}, 32'h0);
    chk({pfx, "_s_rd_pulse"}, {28'h0, s_rd_pulse}, 32'h0);
    chk({pfx, "_state"},      {30'h0, dbg_state}, 32'h0);
  endtask

  // driver + responsive slave model: s_ready rises on ACCESS cycle waits+1
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input int waits,
                         input logic [31:0] srd, output obs_t o);
    o = '{default: '0};
    @(negedge clk);
    s_rdata    = {4{srd}};
    s_ready    = 4'h0;
    m_req      = 1'b1;
    m_we       = we;
    m_addr     = addr;
    m_wdata    = wdata;
    m_size     = size;
    m_unsigned = uns;
    while (!o.done && o.lat < 60) begin
      @(posedge clk);
      #1;
      o.lat++;
      if (m_ready) begin
        o.done  = 1'b1;
        o.rdata = m_rdata;
        o.err   = m_err;
        o.pulse = s_rd_pulse;
        m_req   = 1'b0;
      end
      if (s_sel != 4'h0) begin
        o.sel_cyc++;
        o.sel   |= s_sel;
        o.we    = s_we;
        o.saddr = s_addr;
        o.be    = s_be;
        o.wd    = s_wdata;
        s_ready = (o.sel_cyc > waits) ? 4'hF : 4'h0;
      end else begin
        s_ready = 4'h0;
      end
    end
    m_req = 1'b0;
    @(posedge clk);
    #1;
    o.after = {m_ready, s_rd_pulse};
  endtask

  task automatic check_txn(input string n, input vec_t v, input obs_t o);
    int exp_sel_cyc;
    exp_sel_cyc = (v.e_sel != 4'h0) ? v.waits + 1 : 0;
    chk({n, "_done"},    {31'h0, o.done}, 32'h1);
    chk({n, "_latency"}, o.lat, v.e_lat);
    chk({n, "_err"},     {31'h0, o.err}, {31'h0, v.e_err});
    chk({n, "_rdata"},   o.rdata, v.e_rdata);
    chk({n, "_sel"},     {28'h0, o.sel}, {28'h0, v.e_sel});
    chk({n, "_selcyc"},  o.sel_cyc, exp_sel_cyc);
    chk({n, "_pulse"},   {28'h0, o.pulse}, {28'h0, v.e_pulse});
    chk({n, "_after"},   {27'h0, o.after}, 32'h0);
    if (v.e_sel != 4'h0) begin
      chk({n, "_s_we"},    {31'h0, o.we}, {31'h0, v.we});
      chk({n, "_s_addr"},  o.saddr, v.e_saddr);
      chk({n, "_s_be"},    {28'h0, o.be}, {28'h0, v.e_be});
      chk({n, "_s_wdata"}, o.wd, v.e_wdata);
    end
  endtask

  function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wdata, logic [1:0] size,
                              logic uns, int waits, logic [31:0] srd, int e_lat, logic e_err,
                              logic [31:0] e_rdata, logic [3:0] e_sel, logic [31:0] e_saddr,
                              logic [3:0] e_be, logic [31:0] e_wdata, logic [3:0] e_pulse);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.waits = waits; v.srd = srd; v.e_lat = e_lat; v.e_err = e_err;
    v.e_rdata = e_rdata; v.e_sel = e_sel; v.e_saddr = e_saddr; v.e_be = e_be;
    v.e_wdata = e_wdata; v.e_pulse = e_pulse;
    return v;
  endfunction

  vec_t vecs[13];
  vec_t hv;
  obs_t obs;

  initial begin
    //           we  addr          wdata         sz uns wt srd           lat err rdata         sel     saddr be      wdata         pulse
    vecs[0]  = mk(0, 32'h0040_0008, 32'h0,        2, 0, 0, 32'hDEAD_BEEF, 2, 0, 32'hDEAD_BEEF, 4'b0001, 2, 4'b1111, 32'h0,        4'b0001);
    vecs[1]  = mk(1, 32'h1001_0003, 32'h0000_00A5, 0, 0, 0, 32'h5555_5555, 2, 0, 32'h0,        4'b0010, 0, 4'b1000, 32'hA5A5_A5A5, 4'b0000);
    vecs[2]  = mk(0, 32'h1000_0012, 32'h0,        1, 0, 0, 32'h8001_0000, 2, 0, 32'hFFFF_8001, 4'b1000, 0, 4'b1100, 32'h0,        4'b1000);
    vecs[3]  = mk(0, 32'h1000_0012, 32'h0,        1, 1, 0, 32'h8001_0000, 2, 0, 32'h0000_8001, 4'b1000, 0, 4'b1100, 32'h0,        4'b1000);
    vecs[4]  = mk(0, 32'h1001_0002, 32'h0,        2, 0, 0, 32'hFFFF_FFFF, 1, 1, 32'h0,        4'b0000, 0, 4'b0000, 32'h0,        4'b0000);
    vecs[5]  = mk(0, 32'h2000_0000, 32'h0,        0, 0, 0, 32'hFFFF_FFFF, 1, 1, 32'h0,        4'b0000, 0, 4'b0000, 32'h0,        4'b0000);
    vecs[6]  = mk(0, 32'h0040_0000, 32'h0,        3, 0, 0, 32'hFFFF_FFFF, 1, 1, 32'h0,        4'b0000, 0, 4'b0000, 32'h0,        4'b0000);
    vecs[7]  = mk(0, 32'h0040_0001, 32'h0,        1, 0, 0, 32'hFFFF_FFFF, 1, 1, 32'h0,        4'b0000, 0, 4'b0000, 32'h0,        4'b0000);
    vecs[8]  = mk(0, 32'h0040_0001, 32'h0,        0, 0, 0, 32'h0000_8000, 2, 0, 32'hFFFF_FF80, 4'b0001, 0, 4'b0010, 32'h0,        4'b0001);
    vecs[9]  = mk(0, 32'h1001_0002, 32'h0,        0, 1, 0, 32'h00FE_0000, 2, 0, 32'h0000_00FE, 4'b0010, 0, 4'b0100, 32'h0,        4'b0010);
    vecs[10] = mk(1, 32'h1000_0002, 32'h1234_ABCD, 1, 0, 0, 32'h0,        2, 0, 32'h0,        4'b0100, 0, 4'b1100, 32'hABCD_ABCD, 4'b0000);
    vecs[11] = mk(1, 32'h0040_0010, 32'h1122_3344, 2, 0, 3, 32'h0,        5, 0, 32'h0,        4'b0001, 4, 4'b1111, 32'h1122_3344, 4'b0000);
    vecs[12] = mk(0, 32'h1001_0004, 32'h0,        2, 0, 2, 32'hCAFE_F00D, 4, 0, 32'hCAFE_F00D, 4'b0010, 1, 4'b1111, 32'h0,        4'b0010);

    rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
    m_size = 2'd0; m_unsigned = 1'b0; s_rdata = '0; s_ready = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns,
              vecs[i].waits, vecs[i].srd, obs);
      check_txn($sformatf("v%0d", i), vecs[i], obs);
    end

    // Timeout: slot1, s_ready never rises
    hv = mk(0, 32'h1001_0000, 32'h0, 2, 0, 1000, 32'h1234_5678, 16, 1, 32'h0, 4'b0010, 0, 4'b1111, 32'h0, 4'b0000);
    run_txn(hv.we, hv.addr, hv.wdata, hv.size, hv.uns, hv.waits, hv.srd, obs);
    chk("tmo_done",   {31'h0, obs.done}, 32'h1);
    chk("tmo_latency", obs.lat, 16);
    chk("tmo_selcyc", obs.sel_cyc, 15);
    chk("tmo_err",    {31'h0, obs.err}, 32'h1);
    chk("tmo_rdata",  obs.rdata, 32'h0);
    chk("tmo_pulse",  {28'h0, obs.pulse}, 32'h0);

    // Ready on the 15th ACCESS cycle still succeeds
    run_txn(1'b0, 32'h1001_0000, 32'h0, 2'd2, 1'b0, 14, 32'h1234_5678, obs);
    chk("late_latency", obs.lat, 16);
    chk("late_selcyc",  obs.sel_cyc, 15);
    chk("late_err",     {31'h0, obs.err}, 32'h0);
    chk("late_rdata",   obs.rdata, 32'h1234_5678);
    chk("late_pulse",   {28'h0, obs.pulse}, 32'h0000_0002);

    // Reset while in ACCESS
    @(negedge clk);
    s_rdata = {4{32'h7777_7777}}; s_ready = 4'h0;
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h1001_0000; m_size = 2'd2; m_unsigned = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_sel", {28'h0, s_sel}, 32'h2);
    chk("mid_state", {30'h0, dbg_state}, 32'h1);
    @(negedge clk);
    rst = 1'b1; m_req = 1'b0; s_ready = 4'hF;
    @(posedge clk);
    #1;
    chk_outputs_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0; s_ready = 4'h0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {27'h0, m_ready, s_rd_pulse}, 32'h0);

    hv = mk(0, 32'h0040_0004, 32'h0, 2, 0, 0, 32'h0BAD_F00D, 2, 0, 32'h0BAD_F00D, 4'b0001, 1, 4'b1111, 32'h0, 4'b0001);
    run_txn(hv.we, hv.addr, hv.wdata, hv.size, hv.uns, hv.waits, hv.srd, obs);
    check_txn("fresh", hv, obs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
